// File: rtl/iram_64x16_fifo_ctl.sv
// iram_64x16_fifo_ctl: valid/ready FWFT FIFO over a 64x16 registered-read RAM,
// a 2-entry output skid hides the read latency.
module iram_1r1w1ck_64x16 (
   input  logic        clk,
   input  logic        ena,
   input  logic        wea,
   input  logic [5:0]  addra,
   input  logic [15:0] dia,
   input  logic        enb,
   input  logic [5:0]  addrb,
   output logic [15:0] dob
);
   logic [15:0] mem [64];
   always_ff @(posedge clk) begin
      if (ena && wea) mem[addra] <= dia;
      if (enb) dob <= mem[addrb];
   end
endmodule

module iram_64x16_fifo_ctl #(
   parameter int AFULL_LVL = 56
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        wr_valid,
   input  logic [15:0] wr_data,
   output logic        wr_ready,
   output logic        rd_valid,
   output logic [15:0] rd_data,
   input  logic        rd_ready,
   output logic [6:0]  level,
   output logic        empty,
   output logic        almost_full
);
   localparam int AW = 6;
   localparam int DW = 16;
   localparam logic [6:0] AF = 7'(AFULL_LVL);
   logic [AW-1:0] wptr, rptr;
   logic [6:0]    ram_cnt;
   logic          inflight;
   logic [1:0]    skid_cnt, cnt_p, cnt_n;
   logic [DW-1:0] s0, s1, s0_n, s1_n, dob;
   logic          accept, pop, fetch;
   assign wr_ready    = ram_cnt != 7'd64;
   assign rd_valid    = skid_cnt != 2'd0;
   assign rd_data     = s0;
   assign level       = ram_cnt + {6'b0, inflight} + {5'b0, skid_cnt};
   assign empty       = level == 7'd0;
   assign almost_full = level >= AF;
   assign accept      = wr_valid & wr_ready & ~flush;
   assign pop         = rd_valid & rd_ready;
   // Only fetch if the skid is guaranteed room for the word once it lands.
   assign fetch = ~flush & (ram_cnt != 7'd0) &
                  (({1'b0, skid_cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
   iram_1r1w1ck_64x16 u_ram (
      .clk   (clk),
      .ena   (accept),
      .wea   (accept),
      .addra (wptr),
      .dia   (wr_data),
      .enb   (fetch),
      .addrb (rptr),
      .dob   (dob)
   );
   // Captured word goes to the first free slot after any pop shifts the skid.
   always_comb begin
      cnt_p = skid_cnt - {1'b0, pop};
      s0_n  = (inflight && cnt_p == 2'd0) ? dob : (pop ? s1 : s0);
      s1_n  = (inflight && cnt_p != 2'd0) ? dob : s1;
      cnt_n = cnt_p + {1'b0, inflight};
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
         skid_cnt <= '0;
         s0       <= '0;
         s1       <= '0;
      end else if (flush) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
         skid_cnt <= '0;
         s0       <= '0;
         s1       <= '0;
      end else begin
         wptr     <= accept ? wptr + 6'd1 : wptr;
         rptr     <= fetch ? rptr + 6'd1 : rptr;
         ram_cnt  <= ram_cnt + {6'b0, accept} - {6'b0, fetch};
         inflight <= fetch;
         skid_cnt <= cnt_n;
         s0       <= s0_n;
         s1       <= s1_n;
      end
   end
endmodule
